// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single word-aligned data memory.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie, with no last-grant state.
//
// state | meaning
// IDLE  | waiting for a request; grant winner sees req_ready
// BUSY  | held request drives the memory for one cycle
// RESP  | response presented on the held port until it is consumed
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_write,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_write,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    state_t      state;
    logic        grant0;
    logic        grant1;
    logic        hold_port;
    logic        hold_write;
    logic        hold_err;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        rsp_take;

`ifdef ARB_FIXED_PRIO_EN
    assign grant0 = m0_req_valid;
    assign grant1 = m1_req_valid && !m0_req_valid;
`else
    logic last_grant;

    // On a tie, the port that did not win the previous accept goes first.
    assign grant0 = m0_req_valid && (!m1_req_valid || last_grant);
    assign grant1 = m1_req_valid && (!m0_req_valid || !last_grant);
`endif

    assign m0_req_ready = (state == IDLE) && grant0;
    assign m1_req_ready = (state == IDLE) && grant1;

    assign sel_write = m1_req_ready ? m1_req_write : m0_req_write;
    assign sel_addr  = m1_req_ready ? m1_req_addr  : m0_req_addr;
    assign sel_wdata = m1_req_ready ? m1_req_wdata : m0_req_wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_LIM);

    assign rsp_take = hold_port ? m1_rsp_ready : m0_rsp_ready;

    assign m0_rsp_valid = rsp_valid && !hold_port;
    assign m1_rsp_valid = rsp_valid && hold_port;
    assign m0_rsp_rdata = hold_port ? 32'h0 : rsp_rdata;
    assign m1_rsp_rdata = hold_port ? rsp_rdata : 32'h0;
    assign m0_rsp_err   = rsp_err && !hold_port;
    assign m1_rsp_err   = rsp_err && hold_port;

    // mem_addr/mem_wdata double as the held address and data; they are
    // only non-zero during BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_port  <= 1'b0;
            hold_write <= 1'b0;
            hold_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_ready || m1_req_ready) begin
                        hold_port  <= m1_req_ready;
                        hold_write <= sel_write;
                        hold_err   <= sel_err;
                        mem_we     <= sel_write && !sel_err;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
`ifndef ARB_FIXED_PRIO_EN
                        last_grant <= m1_req_ready;
`endif
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    rsp_rdata <= (!hold_write && !hold_err) ? mem_rdata : 32'h0;
                    rsp_err   <= hold_err;
                    rsp_valid <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= 32'h0;
                    mem_wdata <= 32'h0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single word-aligned data memory between the core's load/store port (port 0) and an auxiliary requester such as a loader or debug master (port 1). Each port issues read or write requests over a valid/ready handshake. The arbiter serializes them: one outstanding transaction at a time, round-robin grant, registered memory drive. It returns a response per request over a valid/ready handshake, flagging misaligned or out-of-range addresses. It sits between the requesters and the memory macro, whose read data is combinational from its address.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the memory; legal word index 0..DEPTH_WORDS-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req_valid, m1_req_valid  input  1  request present.
- m0_req_ready, m1_req_ready  output  1  arbiter accepts request this cycle.
- m0_req_write, m1_req_write  input  1  1 = store, 0 = load.
- m0_req_addr, m1_req_addr  input  32  byte address.
- m0_req_wdata, m1_req_wdata  input  32  store data.
- m0_rsp_valid, m1_rsp_valid  output  1  response present.
- m0_rsp_ready, m1_rsp_ready  input  1  requester consumes response.
- m0_rsp_rdata, m1_rsp_rdata  output  32  load data; 0 for stores and errors.
- m0_rsp_err, m1_rsp_err  output  1  misaligned or out-of-range request.
- mem_we  output  1  memory write strobe.
- mem_addr  output  32  byte address to memory.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, combinational from mem_addr.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state: IDLE.
- **IDLE**
  - mN_req_ready = 1 only for the grant winner when its mN_req_valid = 1; the other port's ready = 0.
  - On accept, capture into holding registers: port id, write, addr, wdata, and err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH_WORDS). Go to BUSY.
- **Arbitration**
  - If only one port is valid, it wins.
  - If both are valid, the port that did not win the previous accept wins.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates only on accept.
- **BUSY**, exactly one cycle:
  - mem_addr = held addr; mem_wdata = held wdata.
  - mem_we = held write && !held err.
  - For a load with no error, mem_rdata is captured into the response register. Otherwise the response data is 0.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1 on the held port only, with rsp_rdata and rsp_err.
  - Held stable until that port's rsp_ready = 1, then go to IDLE.
  - Both req_ready = 0 in BUSY and RESP.
- **Error requests** still produce a response (err = 1, rdata = 0). They never assert mem_we.
- **Idle memory drive**: mem_addr = 0, mem_wdata = 0, mem_we = 0 outside BUSY.
- **Reset mid-transaction**: the transaction is dropped. No mem_we is produced after reset asserts, and no response is issued.

## Timing
- Reset values:
  - All req_ready, rsp_valid, rsp_err, mem_we = 0.
  - rsp_rdata, mem_addr, mem_wdata = 0.
  - state = IDLE; last_grant = 1.
- req_ready is combinational from req_valid and state. It is never asserted for a port whose valid is low.
- Latency from accept edge (cycle N):
  - mem_we / mem_addr valid in cycle N+1.
  - rsp_valid rises in cycle N+2.
- With rsp_ready held high, back-to-back throughput is one transaction per 3 cycles; the next accept can occur in cycle N+3.
- A store's memory write completes at the end of cycle N+1. A load issued afterward observes it.
- Requester inputs may change freely after accept; only held copies are used.

## Configuration
- ARB_FIXED_PRIO_EN
  - **Defined**: port 0 wins every tie; last_grant is not implemented (port 1 can starve).
  - **Undefined (default)**: round-robin as in Operation.

## Test plan
- **Single load:** after reset, memory word 3 = 0xDEADBEEF; m0 load addr 0x0C.
  - m0 accepted in cycle N; mem_addr = 0x0C in N+1; m0_rsp_valid in N+2 with rdata 0xDEADBEEF, err = 0.
- **Store then load:** m1 store addr 0x10 wdata 0x12345678, then m1 load addr 0x10.
  - mem_we high exactly one cycle; load returns 0x12345678.
- **Tie arbitration:** both ports valid continuously after reset, rsp_ready = 1.
  - Grants alternate 0,1,0,1.
  - With ARB_FIXED_PRIO_EN defined: grants 0,0,0,0.
- **Errors:** m0 load addr 0x02, then m0 store addr 0x100 (word 64, DEPTH_WORDS = 64).
  - Both responses err = 1, rdata = 0; mem_we never asserted.
- **Backpressure:** m0 rsp_ready held low 5 cycles.
  - rsp_valid and rdata stable for all 5 cycles; m1 req_ready stays 0 until the response is consumed.
- **Reset mid-transaction:** assert reset during BUSY of a store to 0x04.
  - All outputs return to reset values asynchronously; no response issued; next grant after a tie goes to port 0.
